// File: rtl/maquina_pkg.sv
// Shared channel map and event priority for the Maquina push-button front-end
// and the machine top level.
package maquina_pkg;

  localparam int CH_D   = 0;
  localparam int CH_N   = 1;
  localparam int CH_R   = 2;
  localparam int CH_P   = 3;
  localparam int NUM_CH = 4;

  typedef logic [NUM_CH-1:0] ch_vec_t;

  // Channels listed from highest to lowest priority.
  localparam int PRIO_ORDER [NUM_CH] = '{CH_R, CH_D, CH_N, CH_P};

  // One-hot of the highest-priority set bit in req, zero when req is zero.
  // Walks from lowest to highest priority so the last hit wins.
  function automatic ch_vec_t pick_highest(input ch_vec_t req);
    ch_vec_t pick;
    pick = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req[PRIO_ORDER[k]]) begin
        pick = '0;
        pick[PRIO_ORDER[k]] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/maquina_debounce.sv
// One push-button channel: two-flop synchroniser, stable-count debouncer and
// rising-edge strobe aligned with the edge on which the level goes high.
module maquina_debounce #(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int CNT_W           = 14
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             terminal;

  assign differ   = (s2 != level);
  assign terminal = (cnt == TERM);

  // The level flips on this edge only when the new value is high.
  assign rise = differ & terminal & s2;

  // Bring the asynchronous button level into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Accept a change only after it has held for DEBOUNCE_CYCLES samples;
  // any return to the current level restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (!differ) begin
      cnt <= '0;
    end else if (terminal) begin
      level <= s2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/maquina_sw_conditioner.sv
// Input front-end for tt_Maquina_Top: debounces the P/R/N/D buttons and hands
// their press events to the machine one at a time over valid/ready.
module maquina_sw_conditioner
  import maquina_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int CNT_W           = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] sw_raw,
  input  logic              evt_ready,
  output logic              evt_valid,
  output logic [NUM_CH-1:0] evt_code,
  output logic [NUM_CH-1:0] sw_level,
  output logic [NUM_CH-1:0] overrun
);

  ch_vec_t rise;
  ch_vec_t pending;
  ch_vec_t presented;
  ch_vec_t consume;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    maquina_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (sw_raw[i]),
      .level(sw_level[i]),
      .rise (rise[i])
    );
  end

  // Present the highest-priority pending event; only that bit is consumed.
  always_comb begin
    presented = pick_highest(pending);
    evt_valid = |pending;
    evt_code  = presented;
    consume   = (evt_valid && evt_ready) ? presented : '0;
  end

  // A new press re-arms its bit even when the old event leaves this edge;
  // a press landing on a still-unconsumed event is flagged as a sticky overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= (pending & ~consume) | rise;
      overrun <= overrun | (rise & pending & ~consume);
    end
  end

endmodule
